// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds an external 1-bit full adder LSB first,
// collects the sum bits, and reports carry-out and signed overflow.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      res_sh_q  <= '0;
      carry_q   <= 1'b0;
      bit_cnt_q <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      res_sh_q  <= res_sh_d;
      carry_q   <= carry_d;
      bit_cnt_q <= bit_cnt_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_sh_d  = res_sh_q;
    carry_d   = carry_q;
    bit_cnt_d = bit_cnt_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d    = op_a;
          b_sh_d    = op_b;
          carry_d   = cin;
          bit_cnt_d = '0;
          state_d   = S_ADD;
        end
      end
      S_ADD: begin
        res_sh_d = {fa_sum, res_sh_q[WIDTH-1:1]};
        carry_d  = fa_carry;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        if (bit_cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB
          cout_d  = fa_carry;
          ovf_d   = carry_q ^ fa_carry;
          state_d = S_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_ADD);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_sh_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign fa_a      = busy ? a_sh_q[0] : 1'b0;
  assign fa_b      = busy ? b_sh_q[0] : 1'b0;
  assign fa_c      = busy ? carry_q   : 1'b0;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a behavioural full adder attached
// to the fa_* ports.
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             fa_a, fa_b, fa_c;
  logic             fa_sum, fa_carry;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .busy(busy),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
    .fa_sum(fa_sum), .fa_carry(fa_carry)
  );

  assign fa_sum   = fa_a ^ fa_b ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full operation: accept, wait for result, optional backpressure, release.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] er, input logic ec, input logic eo,
                        input int hold, input bit inject, input bit chk_fa,
                        input logic [7:0] exp_fa);
    int cyc;
    logic [7:0] fa_seq;
    logic [7:0] held;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    op_a = a; op_b = b; cin = ci; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
    cyc = 0;
    fa_seq = '0;
    while (!out_valid && cyc < 40) begin
      if (cyc < 8) begin
        fa_seq[cyc] = fa_a;
        check("busy_add", 32'(busy), 32'd1);
      end
      if (inject) begin
        check("in_ready_add", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", 32'(cyc), 32'd8);
    if (chk_fa) check("fa_a_seq", 32'(fa_seq), 32'(exp_fa));
    check("result", 32'(result), 32'(er));
    check("cout", 32'(cout), 32'(ec));
    check("ovf", 32'(ovf), 32'(eo));
    $display("op a=%02h b=%02h cin=%0d -> result=%02h cout=%0d ovf=%0d latency=%0d",
             a, b, ci, result, cout, ovf, cyc);
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(result), 32'(held));
      check("hold_cout", 32'(cout), 32'(ec));
      check("hold_ovf", 32'(ovf), 32'(eo));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [8:0]  s;
    logic [7:0]  ra, rb;
    logic        rc;
    logic [9:0]  expq[$];
    logic [9:0]  e;
    int          idx, got, cyc, last_acc;

    // Reset state
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
    check("rst_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'h5A);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h00);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h00);
    run_op(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8'h00);
    run_op(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0, 5, 1'b0, 1'b0, 8'h00);

    // Reset three cycles into an addition
    @(negedge clk);
    op_a = 8'h12; op_b = 8'h34; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_cout_ovf", 32'({cout, ovf}), 32'd0);
    check("midrst_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);
    $display("reset asserted mid-add: busy=%0d in_ready=%0d", busy, in_ready);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h00);

    // Back-to-back with in_valid / out_ready held high
    idx = 0; got = 0; cyc = 0; last_acc = -1;
    out_ready = 1'b1;
    while (got < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid && expq.size() > 0) begin
        e = expq.pop_front();
        check("b2b_result", 32'(result), 32'(e[7:0]));
        check("b2b_cout", 32'(cout), 32'(e[8]));
        check("b2b_ovf", 32'(ovf), 32'(e[9]));
        $display("b2b result=%02h cout=%0d ovf=%0d", result, cout, ovf);
        got++;
      end
      if (in_ready) begin
        if (idx < 4) begin
          ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
          op_a = ra; op_b = rb; cin = rc; in_valid = 1'b1;
          s = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
          expq.push_back({(ra[7] == rb[7]) && (s[7] != ra[7]), s[8], s[7:0]});
          $display("b2b accept a=%02h b=%02h cin=%0d at cycle %0d", ra, rb, rc, cyc);
          if (last_acc >= 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd10);
          last_acc = cyc;
          idx++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_count", 32'(got), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
